// File: rtl/ads127l01_capture_ctrl.sv
// ADS127L01 front-end sequencer: ADC reset pulse, START, filter-settle discard,
// then bounded/continuous AXI-Stream capture with fsync-loss watchdog and re-sync.
`timescale 1ns/1ps
module ads127l01_capture_ctrl #(
  parameter int DW        = 24,
  parameter int CNT_W     = 16,
  parameter int RST_PULSE = 16,
  parameter int SETTLE_N  = 8,
  parameter int FSYNC_TO  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             fsync,
  output logic             adc_reset_n,
  output logic             adc_start,
  input  logic             s_axis_tvalid,
  input  logic [DW-1:0]    s_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [DW-1:0]    m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             timeout_err,
  output logic             overrun_err
);
  localparam int PW = $clog2(RST_PULSE + 1);
  localparam int SW = $clog2(SETTLE_N + 1);
  localparam int WW = $clog2(FSYNC_TO + 1);

  typedef enum logic [2:0] {IDLE, ARESET, SETTLE, CAPTURE, DONE} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0] num_q, smp_cnt;
  logic [PW-1:0]    pulse_cnt;
  logic [SW-1:0]    settle_cnt;
  logic [WW-1:0]    wd_cnt;
  logic [2:0]       fs_sync;
  logic             init_q;
  logic             fs_rise, wd_on, wd_fire, pulse_end, settle_end;
  logic             is_last, room, cap_stb, take, drop, go;

  assign fs_rise    = fs_sync[1] & ~fs_sync[2];
  assign wd_on      = (state == SETTLE) || (state == CAPTURE);
  assign wd_fire    = wd_on && !fs_rise && (wd_cnt == WW'(FSYNC_TO - 1));
  assign pulse_end  = (pulse_cnt == PW'(RST_PULSE - 1));
  assign settle_end = s_axis_tvalid && (settle_cnt == SW'(SETTLE_N - 1));
  // Dropped samples still advance smp_cnt, so the next accepted one may be the last.
  assign is_last    = (num_q != '0) && (smp_cnt >= num_q - 1'b1);
  assign room       = !m_axis_tvalid || m_axis_tready;
  assign cap_stb    = (state == CAPTURE) && s_axis_tvalid && !cmd_stop && !wd_fire;
  assign take       = cap_stb && room;
  assign drop       = cap_stb && !room;
  assign go         = (state == IDLE) && cmd_start && !cmd_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (en) begin
      case (state)
        IDLE:    if (go) state_nx = ARESET;
        ARESET:  if (cmd_stop) state_nx = DONE;
                 else if (pulse_end) state_nx = SETTLE;
        SETTLE:  if (cmd_stop) state_nx = DONE;
                 else if (wd_fire) state_nx = ARESET;
                 else if (settle_end) state_nx = CAPTURE;
        CAPTURE: if (cmd_stop) state_nx = DONE;
                 else if (wd_fire) state_nx = ARESET;
                 else if (take && is_last) state_nx = DONE;
        DONE:    if (!m_axis_tvalid) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    adc_reset_n = init_q && (state != ARESET);
    adc_start   = wd_on;
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs_sync       <= '0;
      init_q        <= 1'b0;
      pulse_cnt     <= '0;
      settle_cnt    <= '0;
      wd_cnt        <= '0;
      smp_cnt       <= '0;
      num_q         <= '0;
      timeout_err   <= 1'b0;
      overrun_err   <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (en) begin
      fs_sync <= {fs_sync[1:0], fsync};
      init_q  <= 1'b1;

      if (state == ARESET) pulse_cnt <= pulse_cnt + 1'b1;
      else                 pulse_cnt <= '0;

      if (state != SETTLE)    settle_cnt <= '0;
      else if (s_axis_tvalid) settle_cnt <= settle_cnt + 1'b1;

      if (!wd_on || fs_rise || wd_fire) wd_cnt <= '0;
      else                              wd_cnt <= wd_cnt + 1'b1;

      if (state == IDLE || state == ARESET) smp_cnt <= '0;
      else if (cap_stb && smp_cnt != '1)    smp_cnt <= smp_cnt + 1'b1;

      if (go) begin
        num_q       <= num_samples;
        timeout_err <= 1'b0;
        overrun_err <= 1'b0;
      end else begin
        if (wd_fire) timeout_err <= 1'b1;
        if (drop)    overrun_err <= 1'b1;
      end

      // Timeout flushes the held beat; a new strobe may reload on the handshake cycle.
      if (wd_fire) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end else if (take) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tlast  <= is_last;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ads127l01_capture_ctrl.sv
// Directed bench for ads127l01_capture_ctrl with hand-computed expectations.
`timescale 1ns/1ps
module tb_ads127l01_capture_ctrl;
  localparam int DW = 24;
  localparam int CNT_W = 16;

  logic clk = 0, rst = 1, en = 1, cmd_start = 0, cmd_stop = 0, fsync;
  logic [CNT_W-1:0] num_samples = '0;
  logic s_axis_tvalid = 0, m_axis_tready = 1;
  logic [DW-1:0] s_axis_tdata = '0, m_axis_tdata;
  logic adc_reset_n, adc_start, m_axis_tvalid, m_axis_tlast, busy, timeout_err, overrun_err;
  logic fs_en = 1;

  int errors = 0, checks = 0;
  int rlow = 0;
  logic [DW-1:0] bq_dat[$];
  logic          bq_last[$];
  int b0, r0, nl;

  ads127l01_capture_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .num_samples(num_samples), .fsync(fsync), .adc_reset_n(adc_reset_n),
    .adc_start(adc_start), .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .busy(busy),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  initial begin
    fsync = 0;
    forever begin
      repeat (45) @(posedge clk);
      #2 fsync = fs_en;
      repeat (5) @(posedge clk);
      #2 fsync = 0;
    end
  end

  // Handshakes and ADC-reset-low cycles, observed mid-cycle.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      bq_dat.push_back(m_axis_tdata);
      bq_last.push_back(m_axis_tlast);
    end
    if (!rst && !adc_reset_n) rlow++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [DW-1:0] d);
    s_axis_tvalid = 1; s_axis_tdata = d;
    tick(1);
    s_axis_tvalid = 0;
  endtask

  task automatic start(input logic [CNT_W-1:0] n);
    num_samples = n; cmd_start = 1;
    tick(1);
    cmd_start = 0;
  endtask

  task automatic settle8(input logic [DW-1:0] base);
    for (int i = 0; i < 8; i++) begin
      strobe(base + DW'(i));
      tick(3);
    end
  endtask

  task automatic beat(input string tag, input int idx, input logic [DW-1:0] d, input logic l);
    if (idx < bq_dat.size()) begin
      check({tag, "_dat"}, 32'(bq_dat[idx]), 32'(d));
      check({tag, "_last"}, 32'(bq_last[idx]), 32'(l));
    end else begin
      check({tag, "_missing"}, bq_dat.size(), idx + 1);
    end
  endtask

  initial begin
    tick(3);
    check("rst_reset_n", adc_reset_n, 0);
    check("rst_start", adc_start, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {timeout_err, overrun_err}, 0);
    rst = 0;
    tick(1);
    check("idle_reset_n", adc_reset_n, 1);

    // 1: basic 4-sample burst
    b0 = bq_dat.size(); r0 = rlow;
    start(4);
    check("t1_busy", busy, 1);
    tick(18);
    check("t1_pulse_len", rlow - r0, 16);
    check("t1_adc_start", adc_start, 1);
    settle8('h100);
    check("t1_settle_drop", bq_dat.size() - b0, 0);
    strobe('hA00);
    check("t1_tvalid_next", m_axis_tvalid, 1);
    check("t1_tdata_next", m_axis_tdata, 'hA00);
    tick(3);
    for (int i = 1; i < 4; i++) begin
      strobe('hA00 + DW'(i));
      tick(3);
    end
    tick(5);
    check("t1_beats", bq_dat.size() - b0, 4);
    for (int i = 0; i < 4; i++) beat("t1_beat", b0 + i, 'hA00 + DW'(i), i == 3);
    check("t1_busy_end", busy, 0);
    check("t1_start_end", adc_start, 0);

    // 2: backpressure, overrun, dropped sample counts toward N
    b0 = bq_dat.size();
    start(3); tick(18); settle8('h200);
    m_axis_tready = 0;
    strobe('hB01); tick(2);
    strobe('hB02); tick(2);
    check("t2_overrun", overrun_err, 1);
    check("t2_hold_dat", m_axis_tdata, 'hB01);
    check("t2_hold_last", m_axis_tlast, 0);
    tick(196);
    check("t2_hold_vld", m_axis_tvalid, 1);
    check("t2_hold_dat2", m_axis_tdata, 'hB01);
    m_axis_tready = 1;
    tick(1);
    check("t2_drained", m_axis_tvalid, 0);
    strobe('hB03);
    tick(4);
    check("t2_beats", bq_dat.size() - b0, 2);
    beat("t2_b0", b0, 'hB01, 0);
    beat("t2_b1", b0 + 1, 'hB03, 1);
    check("t2_busy_end", busy, 0);
    check("t2_overrun_sticky", overrun_err, 1);

    // 3: continuous capture then stop with a held beat
    b0 = bq_dat.size();
    start(0);
    check("t3_err_clear", overrun_err, 0);
    tick(18); settle8('h300);
    for (int i = 0; i < 20; i++) begin
      strobe('hC00 + DW'(i));
      tick(2);
    end
    m_axis_tready = 0;
    strobe('hC99);
    cmd_stop = 1; tick(1); cmd_stop = 0;
    check("t3_start_fall", adc_start, 0);
    check("t3_busy_done", busy, 1);
    check("t3_held", m_axis_tvalid, 1);
    m_axis_tready = 1;
    tick(3);
    check("t3_busy_end", busy, 0);
    check("t3_beats", bq_dat.size() - b0, 21);
    nl = 0;
    for (int i = b0; i < bq_last.size(); i++) nl += int'(bq_last[i]);
    check("t3_no_tlast", nl, 0);
    beat("t3_first", b0, 'hC00, 0);
    beat("t3_final", b0 + 20, 'hC99, 0);

    // 4: fsync loss -> timeout, flush, re-sync, restarted burst count
    b0 = bq_dat.size();
    start(2); tick(18); settle8('h400);
    m_axis_tready = 0;
    strobe('hD01);
    fs_en = 0;
    tick(900);
    check("t4_no_early_to", timeout_err, 0);
    check("t4_held", m_axis_tvalid, 1);
    r0 = rlow;
    for (int i = 0; i < 200 && !timeout_err; i++) tick(1);
    check("t4_timeout", timeout_err, 1);
    check("t4_flush", m_axis_tvalid, 0);
    check("t4_rearm_reset", adc_reset_n, 0);
    check("t4_rearm_start", adc_start, 0);
    fs_en = 1; m_axis_tready = 1;
    tick(20);
    check("t4_pulse_len", rlow - r0, 16);
    check("t4_resettle", adc_start, 1);
    settle8('h500);
    strobe('hD02); tick(3);
    strobe('hD03); tick(4);
    check("t4_beats", bq_dat.size() - b0, 2);
    beat("t4_b0", b0, 'hD02, 0);
    beat("t4_b1", b0 + 1, 'hD03, 1);
    check("t4_busy_end", busy, 0);
    check("t4_to_sticky", timeout_err, 1);

    // 5: start+stop together in IDLE; start ignored while capturing
    r0 = rlow;
    num_samples = 5; cmd_start = 1; cmd_stop = 1;
    tick(1);
    cmd_start = 0; cmd_stop = 0;
    check("t5_stay_idle", busy, 0);
    tick(20);
    check("t5_no_pulse", rlow - r0, 0);
    check("t5_err_kept", timeout_err, 1);
    b0 = bq_dat.size();
    start(2);
    check("t5_err_clear", timeout_err, 0);
    tick(18); settle8('h600);
    strobe('hE01); tick(2);
    start(0);
    check("t5_busy_ign", busy, 1);
    tick(2);
    strobe('hE02); tick(4);
    check("t5_beats", bq_dat.size() - b0, 2);
    beat("t5_b1", b0 + 1, 'hE02, 1);
    check("t5_busy_end", busy, 0);

    // 6: asynchronous reset mid-capture with a held beat
    start(0); tick(18); settle8('h700);
    m_axis_tready = 0;
    strobe('hF01); tick(1);
    strobe('hF02);
    check("t6_held", m_axis_tvalid, 1);
    check("t6_overrun", overrun_err, 1);
    #3 rst = 1;
    #1;
    check("t6_tvalid", m_axis_tvalid, 0);
    check("t6_start", adc_start, 0);
    check("t6_reset_n", adc_reset_n, 0);
    check("t6_errs", {timeout_err, overrun_err}, 0);
    check("t6_busy", busy, 0);
    tick(2);
    rst = 0; m_axis_tready = 1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
